dcc_frame_capture: RTL and testbench
====================================

// Module: dcc_frame_capture
// PURPOSE
//  Upstream feeder for the HPS PIO bank. Packs a 32-bit detector sample stream into 32-word frames,
//  timestamps each frame against GPS PPS, and holds one published frame on dcc_data_* until the HPS
//  acknowledges it by toggling hps_read_bit. Also produces pps_count_out, pps_time_out and dcc_time_out.
// PARAMETERS
//  WORDS    32  words per frame (one per dcc_data_N PIO)
//  DATA_W   32  sample / PIO width
//  TIME_W   26  sub-second clock counter width (covers 50 MHz)
//  PPS_W    32  PPS pulse counter width
// PORTS
//  clk_clk              in   1             fabric clock, 50 MHz; the only clock
//  reset_reset_n        in   1             asynchronous, active-low reset
//  pps_in               in   1             raw GPS PPS, asynchronous
//  sample_valid         in   1             sample_data qualifier
//  sample_data          in   DATA_W        detector sample word
//  sample_last          in   1             with sample_valid: last word of frame
//  hps_read_bit         in   1             HPS ack; each toggle releases the published frame
//  dcc_data_out         out  WORDS*DATA_W  published frame; word N at [N*32 +: 32] -> dcc_data_N
//  dcc_time_out         out  TIME_W        sub-second count at the frame's first word
//  pps_count_out        out  PPS_W         PPS edges since reset (wraps)
//  pps_time_out         out  TIME_W        clocks in the last complete PPS period
//  frame_ready          out  1             published frame not yet acknowledged
// BEHAVIOUR
//  Reset: all outputs, counters, banks and state are 0; state IDLE.
//  PPS: 2-flop sync, rising-edge detect. sub_cnt +1 per clock, saturating at all-ones.
//   On an edge: pps_time_out<=sub_cnt+1 (saturating); sub_cnt<=0; pps_count_out+1 (wraps).
//  Ack: hps_read_bit goes through a 2-flop sync. Either edge = ack, 3-cycle latency.
//   An ack when frame_ready=0 is ignored.
//  Capture FSM, capture bank plus publish bank:
//   IDLE: on sample_valid, write word 0, latch ts<=sub_cnt and the frame's PPS count, go FILL.
//         If sample_last is also set, or WORDS=1, go to DONE.
//   FILL: each sample_valid writes word idx. On idx==WORDS-1 or sample_last, go DONE.
//   DONE: if frame_ready=0 or an ack is this cycle: copy bank to dcc_data_out, ts to dcc_time_out,
//         zero-fill unwritten words, frame_ready<=1 next cycle, go IDLE. Otherwise go HOLD.
//   HOLD: wait for an ack, then publish as in DONE. Samples arriving in DONE/HOLD are dropped.
//  Ack and publish in the same cycle: the new frame wins, frame_ready stays 1.
//  dcc_data_out/dcc_time_out are stable while frame_ready=1 (HPS reads them non-atomically).
//  A PPS edge mid-frame does not alter the latched ts.
// CONFIGURATION
//  DCC_DROP_COUNT_EN defined: adds output drop_count[15:0], reset 0.
//   Increments once per dropped sample_valid. Saturates at 16'hFFFF. Cleared on publish.
//  Undefined: no drop_count port; dropped samples are discarded silently.
// STRUCTURE
//  Package dcc_pkg: DCC_WORDS, DCC_DATA_W, DCC_TIME_W, DCC_PPS_W, and
//   typedef enum {IDLE,FILL,DONE,HOLD} cap_state_t.
//  Sub-module pps_timebase: PPS sync, edge detect, sub_cnt, pps_count_out, pps_time_out.
//  Top level holds the FSM, the two banks and the ack synchroniser.
// TESTING
//  1 PPS edges 50_000_000 clocks apart, three times:
//    pps_time_out=50_000_000, pps_count_out=3.
//  2 32 valid words 0x100..0x11F, no ack:
//    frame_ready=1 at word 31 +2 clk; dcc_data word 5 = 0x105; dcc_time_out=sub_cnt at word 0.
//  3 Frame of 4 words, sample_last on the 4th:
//    words 0-3 carry the data, words 4-31 = 0.
//  4 Frame A published, frame B completed, no ack, 10 more samples:
//    output holds A; drop_count=10 with DCC_DROP_COUNT_EN.
//    Toggle hps_read_bit: B published 4 clk later.
//  5 Assert reset_reset_n=0 mid-FILL at word 17, then release:
//    all outputs 0, state IDLE; the next sample lands in word 0.
//  6 No PPS for more than 2^26 clocks:
//    sub_cnt saturates at 0x3FFFFFF; next PPS gives pps_time_out=0x3FFFFFF.

Source files
------------

// File: rtl/dcc_pkg.sv
// dcc_pkg: shared sizes and capture-state encoding for the DCC frame capture block.
package dcc_pkg;
    localparam int DCC_WORDS  = 32;
    localparam int DCC_DATA_W = 32;
    localparam int DCC_TIME_W = 26;
    localparam int DCC_PPS_W  = 32;
    typedef enum logic [1:0] {IDLE, FILL, DONE, HOLD} cap_state_t;
endpackage

// File: rtl/dcc_frame_capture_pps_timebase.sv
// pps_timebase: GPS PPS synchroniser, sub-second clock counter and PPS period/count tracking.
//   clk_i        fabric clock
//   rst_ni       asynchronous active-low reset
//   pps_i        raw asynchronous PPS
//   sub_cnt_o    clocks since the last PPS edge, saturating
//   pps_count_o  PPS edges since reset, wrapping
//   pps_time_o   clocks in the last complete PPS period, saturating
module pps_timebase
    import dcc_pkg::*;
#(
    parameter int TIME_W = DCC_TIME_W,
    parameter int PPS_W  = DCC_PPS_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              pps_i,
    output logic [TIME_W-1:0] sub_cnt_o,
    output logic [PPS_W-1:0]  pps_count_o,
    output logic [TIME_W-1:0] pps_time_o
);
    logic [2:0]        sync_q;
    logic [TIME_W-1:0] sub_cnt_q, pps_time_q, sub_inc;
    logic [PPS_W-1:0]  pps_count_q;
    logic              pps_edge;

    assign pps_edge = sync_q[1] & ~sync_q[2];
    assign sub_inc  = &sub_cnt_q ? sub_cnt_q : sub_cnt_q + TIME_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q      <= '0;
            sub_cnt_q   <= '0;
            pps_time_q  <= '0;
            pps_count_q <= '0;
        end else begin
            sync_q      <= {sync_q[1:0], pps_i};
            sub_cnt_q   <= pps_edge ? '0 : sub_inc;
            pps_time_q  <= pps_edge ? sub_inc : pps_time_q;
            pps_count_q <= pps_edge ? pps_count_q + PPS_W'(1) : pps_count_q;
        end
    end

    assign sub_cnt_o   = sub_cnt_q;
    assign pps_count_o = pps_count_q;
    assign pps_time_o  = pps_time_q;
endmodule

// File: rtl/dcc_frame_capture.sv
// dcc_frame_capture: packs samples into WORDS-word frames, timestamps them and holds one for the HPS.
//   clk_clk        fabric clock (only clock)
//   reset_reset_n  asynchronous active-low reset
//   pps_in         raw GPS PPS
//   sample_valid / sample_data / sample_last   sample stream
//   hps_read_bit   HPS ack, each toggle releases the published frame
//   dcc_data_out   published frame, word N at [N*DATA_W +: DATA_W]
//   dcc_time_out   sub-second count at the published frame's first word
//   pps_count_out / pps_time_out   PPS edge count and last period length
//   frame_ready    published frame not yet acknowledged
//   drop_count     (only with DCC_DROP_COUNT_EN) samples dropped since the last publish
// Build option: define DCC_DROP_COUNT_EN to add the drop_count output.
module dcc_frame_capture
    import dcc_pkg::*;
#(
    parameter int TIME_W = DCC_TIME_W
) (
    input  logic                             clk_clk,
    input  logic                             reset_reset_n,
    input  logic                             pps_in,
    input  logic                             sample_valid,
    input  logic [DCC_DATA_W-1:0]            sample_data,
    input  logic                             sample_last,
    input  logic                             hps_read_bit,
    output logic [DCC_WORDS*DCC_DATA_W-1:0]  dcc_data_out,
    output logic [TIME_W-1:0]                dcc_time_out,
    output logic [DCC_PPS_W-1:0]             pps_count_out,
    output logic [TIME_W-1:0]                pps_time_out,
    output logic                             frame_ready
`ifdef DCC_DROP_COUNT_EN
    ,
    output logic [15:0]                      drop_count
`endif
);
    localparam int IDX_W = DCC_WORDS > 1 ? $clog2(DCC_WORDS) : 1;

    cap_state_t            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DCC_DATA_W-1:0] cap_q [DCC_WORDS];
    logic [DCC_DATA_W-1:0] cap_d [DCC_WORDS];
    logic [DCC_DATA_W-1:0] pub_q [DCC_WORDS];
    logic [DCC_DATA_W-1:0] pub_d [DCC_WORDS];
    logic [TIME_W-1:0]     ts_q, ts_d, pub_ts_q, pub_ts_d, sub_cnt;
    logic                  ready_q, ready_d;
    logic [2:0]            ack_sync_q;
    logic                  ack_q, publish;

    pps_timebase #(.TIME_W(TIME_W), .PPS_W(DCC_PPS_W)) u_timebase (
        .clk_i       (clk_clk),
        .rst_ni      (reset_reset_n),
        .pps_i       (pps_in),
        .sub_cnt_o   (sub_cnt),
        .pps_count_o (pps_count_out),
        .pps_time_o  (pps_time_out)
    );

    // Ack pulse is registered so it lands 3 clocks after the toggle reaches the pin.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ack_sync_q <= '0;
            ack_q      <= 1'b0;
        end else begin
            ack_sync_q <= {ack_sync_q[1:0], hps_read_bit};
            ack_q      <= ack_sync_q[1] ^ ack_sync_q[2];
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cap_d    = cap_q;
        ts_d     = ts_q;
        pub_d    = pub_q;
        pub_ts_d = pub_ts_q;
        ready_d  = ready_q & ~ack_q;
        publish  = 1'b0;
        case (state_q)
            IDLE: if (sample_valid) begin
                // Clearing the bank at frame start gives the zero fill of unwritten words.
                cap_d    = '{default: '0};
                cap_d[0] = sample_data;
                ts_d     = sub_cnt;
                idx_d    = IDX_W'(1);
                state_d  = (sample_last || DCC_WORDS == 1) ? DONE : FILL;
            end
            FILL: if (sample_valid) begin
                cap_d[idx_q] = sample_data;
                idx_d        = idx_q + IDX_W'(1);
                state_d      = (sample_last || idx_q == IDX_W'(DCC_WORDS - 1)) ? DONE : FILL;
            end
            default: begin
                publish = !ready_q || ack_q;
                state_d = publish ? IDLE : HOLD;
            end
        endcase
        if (publish) begin
            pub_d    = cap_q;
            pub_ts_d = ts_q;
            ready_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cap_q    <= '{default: '0};
            pub_q    <= '{default: '0};
            ts_q     <= '0;
            pub_ts_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cap_q    <= cap_d;
            pub_q    <= pub_d;
            ts_q     <= ts_d;
            pub_ts_q <= pub_ts_d;
            ready_q  <= ready_d;
        end
    end

    for (genvar i = 0; i < DCC_WORDS; i++) begin : g_out
        assign dcc_data_out[i*DCC_DATA_W +: DCC_DATA_W] = pub_q[i];
    end
    assign dcc_time_out = pub_ts_q;
    assign frame_ready  = ready_q;

`ifdef DCC_DROP_COUNT_EN
    logic [15:0] drop_q, drop_d;
    logic        drop;

    assign drop   = sample_valid && (state_q == DONE || state_q == HOLD);
    assign drop_d = publish ? '0 : (drop && !(&drop_q)) ? drop_q + 16'd1 : drop_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) drop_q <= '0;
        else drop_q <= drop_d;
    end

    assign drop_count = drop_q;
`endif
endmodule

// File: tb/tb_dcc_frame_capture.sv
// tb_dcc_frame_capture: directed checks of framing, publish/ack handshake, PPS timing and reset.
// The sub-second counter is built 12 bits wide here so saturation and PPS periods fit a short run.
module tb_dcc_frame_capture;
    localparam int TW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pps = 1'b0;
    logic          valid = 1'b0;
    logic [31:0]   data = '0;
    logic          last = 1'b0;
    logic          hps = 1'b0;
    logic [1023:0] dcc_data;
    logic [TW-1:0] dcc_time;
    logic [31:0]   pps_count;
    logic [TW-1:0] pps_time;
    logic          ready;
`ifdef DCC_DROP_COUNT_EN
    logic [15:0]   drops;
`endif

    int n_total = 0;
    int n_bad = 0;

    dcc_frame_capture #(.TIME_W(TW)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .pps_in        (pps),
        .sample_valid  (valid),
        .sample_data   (data),
        .sample_last   (last),
        .hps_read_bit  (hps),
        .dcc_data_out  (dcc_data),
        .dcc_time_out  (dcc_time),
        .pps_count_out (pps_count),
        .pps_time_out  (pps_time),
        .frame_ready   (ready)
`ifdef DCC_DROP_COUNT_EN
        ,
        .drop_count    (drops)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input int n);
        return dcc_data[n*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        valid = 1'b1;
        data  = d;
        last  = l;
        tick();
        valid = 1'b0;
        last  = 1'b0;
    endtask

    // Returns just after the edge on which the DUT registers the PPS edge (sub_cnt is then 0).
    task automatic pps_pulse();
        pps = 1'b1;
        ticks(3);
        pps = 1'b0;
    endtask

    initial begin
        ticks(2);
        check("rst_ready", ready, 0);
        check("rst_data", dcc_data[63:0], 0);
        check("rst_time", dcc_time, 0);
        check("rst_ppscnt", pps_count, 0);
        check("rst_ppstime", pps_time, 0);
        rst_n = 1'b1;
        tick();

        pps_pulse();
        ticks(2997);
        pps_pulse();
        check("pps_period1", pps_time, 3000);
        check("pps_count2", pps_count, 2);
        ticks(2997);
        pps_pulse();
        check("pps_period2", pps_time, 3000);
        check("pps_count3", pps_count, 3);

        ticks(5);
        for (int i = 0; i < 32; i++) send(32'h100 + i, 1'b0);
        check("full_ready_early", ready, 0);
        tick();
        check("full_ready", ready, 1);
        check("full_w0", word(0), 32'h100);
        check("full_w5", word(5), 32'h105);
        check("full_w31", word(31), 32'h11F);
        check("full_time", dcc_time, 5);

        hps = 1'b1;
        ticks(4);
        check("ack_release", ready, 0);
        for (int i = 0; i < 4; i++) send(32'hA0 + i, i == 3);
        tick();
        check("short_ready", ready, 1);
        check("short_w0", word(0), 32'hA0);
        check("short_w3", word(3), 32'hA3);
        check("short_w4", word(4), 0);
        check("short_w31", word(31), 0);

        for (int i = 0; i < 4; i++) send(32'hB0 + i, i == 3);
        for (int i = 0; i < 10; i++) send(32'hD0 + i, 1'b0);
        check("hold_w0", word(0), 32'hA0);
        check("hold_ready", ready, 1);
`ifdef DCC_DROP_COUNT_EN
        check("drop_cnt", drops, 10);
`endif
        hps = 1'b0;
        ticks(3);
        check("ack_lat3_w0", word(0), 32'hA0);
        tick();
        check("ack_lat4_w0", word(0), 32'hB0);
        check("ack_lat4_w3", word(3), 32'hB3);
        check("ack_lat4_w4", word(4), 0);
        check("ack_lat4_ready", ready, 1);
`ifdef DCC_DROP_COUNT_EN
        check("drop_clr", drops, 0);
`endif

        for (int i = 0; i < 17; i++) send(32'hE0 + i, 1'b0);
        rst_n = 1'b0;
        #2;
        check("mid_rst_ready", ready, 0);
        check("mid_rst_w0", word(0), 0);
        check("mid_rst_time", dcc_time, 0);
        check("mid_rst_ppscnt", pps_count, 0);
        check("mid_rst_ppstime", pps_time, 0);
        tick();
        rst_n = 1'b1;
        tick();
        send(32'hF0, 1'b1);
        tick();
        check("post_rst_ready", ready, 1);
        check("post_rst_w0", word(0), 32'hF0);
        check("post_rst_w1", word(1), 0);

        hps = 1'b1;
        ticks(4);
        check("ack2_release", ready, 0);
        ticks(4200);
        send(32'h77, 1'b1);
        tick();
        check("sat_w0", word(0), 32'h77);
        check("sat_time", dcc_time, 12'hFFF);
        pps_pulse();
        check("sat_ppstime", pps_time, 12'hFFF);
        check("sat_ppscnt", pps_count, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
